// File: rtl/search_ram_ctrl.sv
// search_ram_ctrl: arbitrated bucket lookup over a shared
// single-port search RAM, host config writes take priority.
module search_ram_ctrl #(
  parameter int N_REQ    = 2,
  parameter int BUCKET_W = 2,
  parameter int ADDR_W   = 7,
  parameter int KEY_W    = 24,
  parameter int DATA_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*BUCKET_W-1:0] req_bucket,
  input  logic [N_REQ*KEY_W-1:0]    req_key,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic                      rsp_hit,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [3:0]                rsp_idx,
  input  logic                      cfg_wr_en,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [KEY_W+DATA_W-1:0]   cfg_wdata,
  output logic                      cfg_ready,
  output logic                      ram_rd_en,
  output logic                      ram_wr_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [KEY_W+DATA_W-1:0]   ram_wdata,
  input  logic [KEY_W+DATA_W-1:0]   ram_rdata
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int W_W  = KEY_W + DATA_W;
  localparam logic [KEY_W-1:0] KEY_NONE = '1;

  typedef enum logic [1:0] {IDLE, CTRL, SCAN, DONE} state_t;
  state_t state, state_nxt;

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   win_q;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic              grant;
  logic [KEY_W-1:0]  key_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_nxt;
  logic [3:0]        idx_q;
  logic [4:0]        cnt_q;
  logic [4:0]        cnt_raw;
  logic [4:0]        cnt_rd;
  logic [KEY_W-1:0]  ent_key;
  logic              ent_hit;
  logic              ent_last;

  // round-robin search starts one past the last winner
  always_comb begin
    int c;
    c       = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = (int'(ptr_q) + k) % N_REQ;
      if (!gnt_any && req_valid[c]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(c);
      end
    end
  end

  assign base_nxt = ADDR_W'(req_bucket[gnt_id*BUCKET_W +: BUCKET_W])
                  * ADDR_W'(17);
  assign grant    = (state == IDLE) && !cfg_wr_en && gnt_any;
  assign cnt_raw  = ram_rdata[16:12];
  assign cnt_rd   = (cnt_raw > 5'd16) ? 5'd16 : cnt_raw;
  assign ent_key  = ram_rdata[W_W-1:DATA_W];
  assign ent_hit  = (ent_key == key_q) && (ent_key != KEY_NONE);
  assign ent_last = ({1'b0, idx_q} == cnt_q - 5'd1);
  assign cfg_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    ram_rd_en = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (cfg_wr_en) begin
            ram_wr_en = 1'b1;
            ram_addr  = cfg_addr;
            ram_wdata = cfg_wdata;
          end else if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
            ram_rd_en = 1'b1;
            ram_addr  = base_nxt;
            state_nxt = CTRL;
          end
        end
        CTRL: begin
          if (cnt_rd == 5'd0) begin
            state_nxt = DONE;
          end else begin
            ram_rd_en = 1'b1;
            ram_addr  = base_q + ADDR_W'(1);
            state_nxt = SCAN;
          end
        end
        SCAN: begin
          if (ent_hit || ent_last) begin
            state_nxt = DONE;
          end else begin
            ram_rd_en = 1'b1;
            ram_addr  = base_q + ADDR_W'(idx_q)
                      + ADDR_W'(2);
          end
        end
        DONE: begin
          rsp_valid[win_q] = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr_q    <= ID_W'(N_REQ - 1);
      win_q    <= '0;
      key_q    <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      rsp_hit  <= 1'b0;
      rsp_data <= '0;
      rsp_idx  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (grant) begin
            win_q  <= gnt_id;
            key_q  <= req_key[gnt_id*KEY_W +: KEY_W];
            base_q <= base_nxt;
          end
        end
        CTRL: begin
          cnt_q <= cnt_rd;
          idx_q <= '0;
          if (cnt_rd == 5'd0) begin
            rsp_hit  <= 1'b0;
            rsp_data <= '0;
            rsp_idx  <= '0;
          end
        end
        SCAN: begin
          if (ent_hit) begin
            rsp_hit  <= 1'b1;
            rsp_data <= ram_rdata[DATA_W-1:0];
            rsp_idx  <= idx_q;
          end else if (ent_last) begin
            rsp_hit  <= 1'b0;
            rsp_data <= '0;
            rsp_idx  <= '0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        DONE: ptr_q <= win_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_search_ram_ctrl.sv
// tb_search_ram_ctrl: directed + random lookups checked against
// a bucket-scan reference model and a 1-cycle RAM model.
module tb_search_ram_ctrl;
  localparam int N  = 2;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*2-1:0]  req_bucket = '0;
  logic [N*24-1:0] req_key = '0;
  logic [N-1:0]  rsp_valid;
  logic          rsp_hit;
  logic [31:0]   rsp_data;
  logic [3:0]    rsp_idx;
  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [55:0]   cfg_wdata = '0;
  logic          cfg_ready;
  logic          ram_rd_en;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [55:0]   ram_wdata;
  logic [55:0]   ram_rdata = '0;

  logic [55:0] ram  [128];
  logic [55:0] gold [128];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  search_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bucket(req_bucket), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_data(rsp_data), .rsp_idx(rsp_idx),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 128; i++) ram[i] <= '0;
    end else begin
      if (ram_wr_en) ram[ram_addr] <= ram_wdata;
      if (ram_rd_en) ram_rdata <= ram[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
    logic [3:0]  idx;
    logic [4:0]  lat;
    logic [4:0]  reads;
  } res_t;

  // first matching entry among the first min(count,16) entries
  function automatic res_t model(input int b, input logic [23:0] k);
    res_t r;
    int base;
    int cnt;
    r = '0;
    base = 17 * b;
    cnt = int'(gold[base][16:12]);
    if (cnt > 16) cnt = 16;
    r.lat = 5'(cnt + 2);
    r.reads = 5'(cnt + 1);
    for (int i = cnt - 1; i >= 0; i--) begin
      if (k != 24'hFFFFFF && gold[base+1+i][55:32] == k) begin
        r.hit = 1'b1;
        r.data = gold[base+1+i][31:0];
        r.idx = 4'(i);
        r.lat = 5'(i + 3);
        r.reads = 5'(i + 2);
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v,
                                           input int p);
    logic [N-1:0] g;
    logic f;
    g = '0;
    f = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!f && v[(p + k) % N]) begin
        g[(p + k) % N] = 1'b1;
        f = 1'b1;
      end
    end
    return g;
  endfunction

  logic         m_act = 1'b0;
  int           m_due = 0;
  int           m_id = 0;
  int           m_ptr = N - 1;
  int           m_nrd = 0;
  res_t         m_cur = '0;
  res_t         m_last = '0;
  logic [N-1:0] exp_rdy;
  logic [N-1:0] exp_rsp;
  logic         m_idle;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_ptr = N - 1;
      m_last = '0;
      chk("rst_outs", {req_ready, rsp_valid, rsp_hit, rsp_data,
          rsp_idx, ram_rd_en, ram_wr_en, ram_addr}, 64'd0);
      chk("rst_wdata", ram_wdata, 64'd0);
      chk("rst_cfg_ready", cfg_ready, 64'd1);
    end else begin
      m_idle = !m_act;
      exp_rdy = '0;
      if (m_idle && !cfg_wr_en) exp_rdy = rr_pick(req_valid, m_ptr);
      chk("req_ready", req_ready, exp_rdy);
      chk("cfg_ready", cfg_ready, m_idle);
      chk("ram_wr_en", ram_wr_en, m_idle && cfg_wr_en);
      if (m_idle && cfg_wr_en)
        chk("ram_wr_word", {ram_addr, ram_wdata}, {cfg_addr, cfg_wdata});
      chk("rd_wr_excl", ram_rd_en && ram_wr_en, 64'd0);
      if (exp_rdy != '0) begin
        for (int r = 0; r < N; r++) if (exp_rdy[r]) m_id = r;
        m_cur = model(int'(req_bucket[m_id*2 +: 2]),
                      req_key[m_id*24 +: 24]);
        m_act = 1'b1;
        m_due = cyc + int'(m_cur.lat);
        m_nrd = 0;
      end
      if (m_act && ram_rd_en) m_nrd++;
      exp_rsp = '0;
      if (m_act && cyc == m_due) begin
        exp_rsp[m_id] = 1'b1;
        m_last = m_cur;
        m_ptr = m_id;
        m_act = 1'b0;
        chk("rd_count", m_nrd, m_cur.reads);
      end
      chk("rsp_valid", rsp_valid, exp_rsp);
      chk("rsp_fields", {rsp_hit, rsp_data, rsp_idx},
          {m_last.hit, m_last.data, m_last.idx});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [55:0] w);
    cfg_wr_en = 1'b1;
    cfg_addr = AW'(a);
    cfg_wdata = w;
    gold[a] = w;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic present(input int r, input int b, input logic [23:0] k);
    req_bucket[r*2 +: 2] = 2'(b);
    req_key[r*24 +: 24] = k;
    req_valid[r] = 1'b1;
  endtask

  task automatic wait_grant(input int r, output int t);
    int n;
    n = 0;
    t = -1;
    while (n < 60 && t < 0) begin
      @(negedge clk);
      n++;
      if (req_ready[r]) t = cyc;
    end
    if (t < 0) chk("grant_timeout", 64'd1, 64'd0);
    step();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r, input int t0, output int lat,
                          output logic h, output logic [31:0] d,
                          output logic [3:0] ix);
    int n;
    n = 0;
    lat = -1;
    h = 1'b0;
    d = '0;
    ix = '0;
    while (n < 40 && lat < 0) begin
      @(negedge clk);
      n++;
      if (rsp_valid[r]) begin
        lat = cyc - t0;
        h = rsp_hit;
        d = rsp_data;
        ix = rsp_idx;
      end
    end
    if (lat < 0) chk("rsp_timeout", 64'd1, 64'd0);
  endtask

  task automatic lookup(input string nm, input int r, input int b,
                        input logic [23:0] k, input logic eh,
                        input logic [31:0] ed, input logic [3:0] ei,
                        input int el);
    int t0;
    int lat;
    logic h;
    logic [31:0] d;
    logic [3:0] ix;
    present(r, b, k);
    wait_grant(r, t0);
    wait_rsp(r, t0, lat, h, d, ix);
    chk({nm, "_hit"}, h, eh);
    chk({nm, "_data"}, d, ed);
    chk({nm, "_idx"}, ix, ei);
    chk({nm, "_lat"}, lat, el);
    step();
  endtask

  function automatic logic [23:0] rkey();
    int s;
    s = $urandom_range(0, 7);
    return (s == 7) ? 24'hFFFFFF : 24'(s);
  endfunction

  initial begin
    int t_w;
    int t_g;
    int lat;
    int ng;
    int n;
    int order [3];
    logic h;
    logic [31:0] d;
    logic [3:0] ix;
    logic [23:0] k0 [7];
    logic [23:0] kk;
    logic [N-1:0] gseen;

    for (int i = 0; i < 128; i++) gold[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready_lit", cfg_ready, 64'd1);
    chk("rst_rsp_valid_lit", rsp_valid, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    k0 = '{24'h000001, 24'h000003, 24'h000006, 24'h00000D,
           24'h00000E, 24'h000300, 24'h005000};
    cfg_write(0, {24'h0, 32'h00007000});
    for (int i = 0; i < 7; i++)
      cfg_write(1 + i, {k0[i], (i == 3) ? 32'h11111111
                                        : 32'hA0000000 + 32'(i)});
    cfg_write(17, {24'hFFFFFF, 32'hFFFE0FFF});
    cfg_write(18, {24'h000042, 32'h42424242});
    cfg_write(34, {24'h0, 32'hC0017000});
    for (int i = 0; i < 16; i++) begin
      kk = (i == 5) ? 24'hFFFFFF : (i == 11) ? 24'h0FFFFF :
           (i == 15) ? 24'h0ABCDE : 24'h200000 + 24'(i);
      cfg_write(35 + i, {kk, (i == 11) ? 32'hFFFFFFFF
                                       : 32'hB0000000 + 32'(i)});
    end
    cfg_write(51, {24'h0, 32'h00004000});
    for (int i = 0; i < 4; i++)
      cfg_write(52 + i, {24'(i), 32'hC0000000 + 32'(i)});

    lookup("b0_hit", 0, 0, 24'h00000D, 1'b1, 32'h11111111, 4'd3, 6);
    lookup("b0_miss", 0, 0, 24'h000005, 1'b0, 32'h0, 4'd0, 9);
    lookup("b0_e0", 1, 0, 24'h000001, 1'b1, 32'hA0000000, 4'd0, 3);
    lookup("b2_ffff", 1, 2, 24'hFFFFFF, 1'b0, 32'h0, 4'd0, 18);
    lookup("b2_e11", 0, 2, 24'h0FFFFF, 1'b1, 32'hFFFFFFFF, 4'd11, 14);
    lookup("b2_e15", 1, 2, 24'h0ABCDE, 1'b1, 32'hB000000F, 4'd15, 18);
    lookup("b1_cnt0", 0, 1, 24'h000042, 1'b0, 32'h0, 4'd0, 2);

    cfg_wr_en = 1'b1;
    cfg_addr = AW'(52);
    cfg_wdata = {24'h123456, 32'hCAFEF00D};
    gold[52] = cfg_wdata;
    present(0, 3, 24'h123456);
    t_w = cyc;
    @(negedge clk);
    chk("prio_no_grant", req_ready, 64'd0);
    chk("prio_wr", ram_wr_en, 64'd1);
    step();
    cfg_wr_en = 1'b0;
    wait_grant(0, t_g);
    chk("prio_grant_delay", t_g - t_w, 64'd1);
    wait_rsp(0, t_g, lat, h, d, ix);
    chk("wb_hit", h, 64'd1);
    chk("wb_data", d, 64'hCAFEF00D);
    chk("wb_idx", ix, 64'd0);
    chk("wb_lat", lat, 64'd3);
    step();

    present(1, 2, 24'h0ABCDE);
    wait_grant(1, t_g);
    repeat (3) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_rsp_valid", rsp_valid, 64'd0);
    chk("rstmid_rd", ram_rd_en, 64'd0);
    chk("rstmid_hold", {rsp_hit, rsp_data}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    lookup("rerun", 1, 2, 24'h0ABCDE, 1'b1, 32'hB000000F, 4'd15, 18);

    present(0, 0, 24'h00000E);
    present(1, 3, 24'h000002);
    ng = 0;
    n = 0;
    while (ng < 3 && n < 200) begin
      @(negedge clk);
      n++;
      for (int r = 0; r < N; r++)
        if (req_ready[r] && ng < 3) begin
          order[ng] = r;
          ng++;
        end
    end
    step();
    req_valid = '0;
    chk("rr_grants", ng, 64'd3);
    chk("rr_first", order[0], 64'd0);
    chk("rr_second", order[1], 64'd1);
    chk("rr_third", order[2], 64'd0);
    repeat (25) step();

    gseen = '0;
    for (int it = 0; it < 800; it++) begin
      for (int r = 0; r < N; r++) begin
        if (gseen[r]) begin
          req_valid[r] = 1'b0;
        end else if (req_valid[r]) begin
          if ($urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          present(r, $urandom_range(0, 3), rkey());
        end
      end
      cfg_wr_en = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        cfg_addr = AW'($urandom_range(0, 67));
        cfg_wdata = {rkey(), 32'($urandom)};
        cfg_wr_en = 1'b1;
        if (cfg_ready) gold[cfg_addr] = cfg_wdata;
      end
      @(negedge clk);
      gseen = req_ready;
      step();
    end
    cfg_wr_en = 1'b0;
    req_valid = '0;
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
